// File: rtl/countdown_16bit.sv
`default_nettype none
// ============================================================================
// Module   : countdown_16bit
// Brief    : 16-bit down-counter/timer with load, start/stop, enable tick,
//            auto-reload and terminal-count pulse around a half-subtractor chain.
// Revision : 1.0 - initial release
// ============================================================================

module countdown_16bit_hsub (
    input  wire a,
    input  wire bin,
    output wire diff,
    output wire bout
);
    wire w_na;

    xor u_xor (diff, a, bin);
    not u_not (w_na, a);
    and u_and (bout, w_na, bin);
endmodule

module countdown_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        stop,
    input  logic        en,
    input  logic        auto_reload,
    output logic [15:0] count,
    output logic        busy,
    output logic        done
);
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_reload;
    logic        r_busy;
    logic        r_done;

    wire  [16:0] w_borrow;
    wire  [15:0] w_next;
    logic        w_zero;
    logic        w_one;

    assign w_borrow[0] = 1'b1;

    generate
        for (genvar i = 0; i < 16; i++) begin : g_chain
            countdown_16bit_hsub u_hsub (
                .a    (r_count[i]),
                .bin  (w_borrow[i]),
                .diff (w_next[i]),
                .bout (w_borrow[i+1])
            );
        end
    endgenerate

    // A borrow out of the top stage only happens when every bit was zero.
    assign w_zero = w_borrow[16];
    assign w_one  = (r_count == 16'h0001);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= 16'h0000;
            r_reload <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                // Load suppresses start and decrement but a concurrent stop still pauses.
                r_count  <= load_val;
                r_reload <= load_val;
                if (r_state == S_RUN && stop) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!stop && start) begin
                            if (w_zero) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else if (en) begin
                            if (w_zero) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else if (w_one) begin
                                r_done <= 1'b1;
                                if (auto_reload && (r_reload != 16'h0000)) begin
                                    r_count <= r_reload;
                                end else begin
                                    r_count <= 16'h0000;
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_count <= w_next;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_16bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_16bit
// Brief    : Directed self-checking bench for countdown_16bit.
// Revision : 1.0 - initial release
// ============================================================================

module tb_countdown_16bit;
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        stop;
    logic        en;
    logic        auto_reload;
    logic [15:0] count;
    logic        busy;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;

    countdown_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%04h want=0x%04h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [15:0] c, input logic b, input logic d);
        check_val({tag, ".count"}, count, c);
        check_val({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
        check_val({tag, ".done"}, {15'd0, done}, {15'd0, d});
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic ripple(input logic [15:0] v, input logic [15:0] exp);
        do_load(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        check_state("ripple", exp, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_state("ripple_stop", exp, 1'b0, 1'b0);
    endtask

    logic [15:0] basic_cnt [4] = '{16'd3, 16'd2, 16'd1, 16'd0};
    logic        basic_bsy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        basic_dn  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // Reset with arbitrary inputs present
        rst = 1'b1;
        load = 1'($urandom); load_val = 16'($urandom); start = 1'($urandom);
        stop = 1'($urandom); en = 1'($urandom); auto_reload = 1'($urandom);
        tick();
        load = 1'($urandom); load_val = 16'($urandom); start = 1'($urandom);
        tick();
        check_state("reset", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0; load_val = 16'h0; start = 1'b0;
        stop = 1'b0; en = 1'b0; auto_reload = 1'b0;

        // Zero-length timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        check_state("zero_start", 16'h0000, 1'b0, 1'b1);
        tick();
        check_state("zero_after", 16'h0000, 1'b0, 1'b0);

        // Basic countdown from 3
        do_load(16'h0003);
        check_state("basic_load", 16'h0003, 1'b0, 1'b0);
        start = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            check_state($sformatf("basic%0d", i), basic_cnt[i], basic_bsy[i], basic_dn[i]);
        end
        tick();
        check_state("basic_end", 16'h0000, 1'b0, 1'b0);
        en = 1'b0;

        // Borrow ripple
        ripple(16'h8000, 16'h7FFF);
        ripple(16'h0100, 16'h00FF);
        ripple(16'hFFFF, 16'hFFFE);

        // Auto-reload with period 2
        auto_reload = 1'b1;
        do_load(16'h0002);
        start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        check_state("ar_start", 16'h0002, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) check_state($sformatf("ar%0d", i), 16'h0001, 1'b1, 1'b0);
            else            check_state($sformatf("ar%0d", i), 16'h0002, 1'b1, 1'b1);
        end
        stop = 1'b1; en = 1'b0; auto_reload = 1'b0;
        tick();
        stop = 1'b0;
        check_state("ar_stop", 16'h0002, 1'b0, 1'b0);

        // Pause and resume
        do_load(16'h000A);
        start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_state("pause_at5", 16'h0005, 1'b1, 1'b0);
        stop = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            check_state($sformatf("paused%0d", i), 16'h0005, 1'b0, 1'b0);
        end
        stop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_state("resume", 16'h0005, 1'b1, 1'b0);
        tick();
        check_state("resume_dec", 16'h0004, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        tick();
        check_state("en_low_hold", 16'h0004, 1'b1, 1'b0);

        // Reload at count 4 during RUN; en high but load blocks decrement
        en = 1'b1;
        do_load(16'h0007);
        check_state("load_in_run", 16'h0007, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check_state("before_rst", 16'h0003, 1'b1, 1'b0);

        // Reset mid-run: everything clears, no done pulse
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_state("rst_mid", 16'h0000, 1'b0, 1'b0);
        tick();
        check_state("rst_after", 16'h0000, 1'b0, 1'b0);

        // load with stop while running pauses and loads
        do_load(16'h0005);
        start = 1'b1;
        tick();
        start = 1'b0;
        load = 1'b1; load_val = 16'h0009; stop = 1'b1;
        tick();
        load = 1'b0; stop = 1'b0; en = 1'b0;
        check_state("load_stop", 16'h0009, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/countdown_16bit.md
# countdown_16bit

Sequential 16-bit down-counter/timer, the decrementing counterpart to the team's 16-bit half-adder incrementer. The next-value datapath is a ripple chain of 16 half-subtractors built from the same gate primitives as the incrementer. A small FSM wraps the chain and adds parallel load, start/stop control, a count-enable tick, optional auto-reload, and a terminal-count pulse. It serves as the timer/delay element for the lab designs and is paired with the incrementer for up/down counting.

## Interface
- No parameters; width fixed at 16.
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous reset, active-high
- load  input  1  writes load_val into count and the reload register
- load_val  input  16  value for load
- start  input  1  level-sampled; begins or resumes counting
- stop  input  1  level-sampled; pauses counting, count held
- en  input  1  count-enable tick; decrement happens only on cycles with en=1
- auto_reload  input  1  on terminal count, reload instead of stopping
- count  output  16  current counter value, registered
- busy  output  1  high while FSM is in RUN, registered
- done  output  1  one-cycle terminal-count pulse, registered

## Operation
- Datapath: bin[0]=1; diff[i]=count[i]^bin[i]; bin[i+1]=~count[i]&bin[i]; next = diff (count-1 mod 2^16). Built from half-subtractor cells using xor/and/not primitives.
- States: IDLE and RUN. busy=1 exactly in RUN.
- Per-edge priority: rst > load > stop > start > decrement.
- rst: count=0, reload register=0, busy=0, done=0, state=IDLE.
- load, any state: count<=load_val and reload<=load_val. State is unchanged. No decrement that cycle, even if en=1.
- IDLE + start + count!=0 → RUN.
- IDLE + start + count==0 → stay IDLE, done pulses one cycle. This is a zero-length timeout.
- RUN + stop → IDLE, count held.
- RUN + start has no extra effect.
- RUN + en=0: count held.
- RUN + en=1 + count>1: count<=count-1.
- RUN + en=1 + count==1:
  - done<=1.
  - If auto_reload=0: count<=0 and state→IDLE.
  - If auto_reload=1: count<=reload and state stays RUN. If reload==0, count<=0 and state→IDLE.
- done is 0 on every cycle other than the terminal cycles above.
- Count never underflows. Decrement from 0 cannot occur in RUN.

## Timing
- All outputs are registered. Reset values: count=0x0000, busy=0, done=0.
- load at edge N: count=load_val visible after edge N.
- start at edge N (from IDLE): busy=1 after edge N. The first decrement is at edge N+1 if en=1.
- With en held high, a load of V followed by start gives V decrements over V cycles. Then done=1, count=0 and busy=0, all in the same cycle, starting V edges after start.
- Auto-reload with en held high: done has period V cycles. count sequence is V, V-1, …, 1, V, …
- stop and start asserted in the same cycle: stop wins. Pausing takes effect at that edge.
- load and stop in the same cycle while in RUN: count is loaded, state→IDLE.
- rst mid-RUN: all state clears at that edge. No done pulse is emitted.
- The combinational borrow chain has a 16-stage critical path and must close at the target clock.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs → count=0x0000, busy=0, done=0 on the following cycle.
- Basic countdown:
  - Stimulus: load 0x0003, then start, en=1 throughout.
  - Required: count 3,2,1,0 on successive cycles. done=1 only in the cycle count reads 0. busy falls in that same cycle.
- Borrow ripple, each with start and a single en pulse:
  - load 0x8000 → 0x7FFF.
  - load 0x0100 → 0x00FF.
  - load 0xFFFF → 0xFFFE.
- Auto-reload:
  - Stimulus: auto_reload=1, load 0x0002, start, en=1 for 8 cycles.
  - Required: count 2,1,2,1,… with done=1 on each cycle that shows 2 after a 1. busy stays 1.
- Pause/stall:
  - Stimulus: load 0x000A, start, en=1 until count=5. Then stop for 3 cycles, then start again.
  - Required: count held at 5 with busy=0 during the stop, then decrement resumes.
  - Also toggle en=0 during RUN and check count holds.
- Corners:
  - start with count=0 → single done pulse, busy stays 0.
  - load 0x0007 during RUN at count 4 → count=7, still RUN.
  - rst at count 3 in RUN → count=0, no done pulse.
